// File: rtl/shuttle_ctrl.sv
// shuttle_ctrl: two-terminal shuttle controller. Passengers queue at stop 0 (A)
// and stop NUM_STOPS-1 (B). The shuttle boards them, moves one stop per step
// tick, burns fuel per passenger, refuels at terminals and at the gas stop, and
// collects fares. All shuttle state advances only on step ticks. The queues
// update on every clock edge.
module shuttle_ctrl #(
  parameter int NUM_STOPS  = 7,
  parameter int GAS_POS    = 3,
  parameter int CAP        = 2,
  parameter int FARE_UP    = 30,
  parameter int FARE_DOWN  = 20,
  parameter int REV_MAX    = 90,
  parameter int GAS_MAX    = 20,
  parameter int GAS_REFILL = 10,
  parameter int GAS_COST   = 10,
  parameter int GAS_BURN   = 5,
  parameter int TICK_DIV   = 2**26,
  localparam int CW = $clog2(CAP + 1),
  localparam int RW = $clog2(REV_MAX + 1),
  localparam int GW = $clog2(GAS_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arrive_a,
  input  logic                 arrive_b,
  output logic [CW-1:0]        wait_a,
  output logic [CW-1:0]        wait_b,
  output logic [CW-1:0]        bus_pass,
  output logic [NUM_STOPS-1:0] pos,
  output logic                 dir,
  output logic [RW-1:0]        revenue,
  output logic [GW-1:0]        gas,
  output logic [2:0]           state,
  output logic                 step
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int FMAX = (FARE_UP > FARE_DOWN) ? FARE_UP : FARE_DOWN;
  localparam int AW   = $clog2(REV_MAX + CAP*FMAX + GAS_MAX + GAS_REFILL
                               + GAS_COST + CAP*GAS_BURN + 1) + 1;

  typedef enum logic [2:0] {
    S_WAIT     = 3'd0,
    S_BOARD    = 3'd1,
    S_REFUEL_T = 3'd2,
    S_DRIVE    = 3'd3,
    S_BURN_T   = 3'd4,
    S_ALIGHT   = 3'd5,
    S_BURN_G   = 3'd6,
    S_REFUEL_G = 3'd7
  } state_t;

  state_t               st, st_nx;
  logic [TW-1:0]        cnt;
  logic [CW-1:0]        bp_nx, here, other, qa_base, qb_base, qa_nx, qb_nx;
  logic [NUM_STOPS-1:0] pos_nx;
  logic                 dir_nx, at_a, clr_a, clr_b;
  logic [RW-1:0]        rev_nx;
  logic [GW-1:0]        gas_nx;
  logic [AW-1:0]        fare, sum, burn;

  assign step  = (cnt == TW'(TICK_DIV - 1));
  assign state = st;

  // Next-state and datapath decisions, evaluated from the current registers
  always_comb begin
    st_nx  = st;
    bp_nx  = bus_pass;
    pos_nx = pos;
    dir_nx = dir;
    rev_nx = revenue;
    gas_nx = gas;
    clr_a  = 1'b0;
    clr_b  = 1'b0;
    sum    = '0;
    burn   = '0;
    at_a   = pos[0];
    here   = at_a ? wait_a : wait_b;
    other  = at_a ? wait_b : wait_a;
    fare   = at_a ? AW'(FARE_UP) : AW'(FARE_DOWN);
    case (st)
      S_WAIT: begin
        if (here != '0) begin
          st_nx = S_BOARD;
        end else if (other != '0) begin
          st_nx  = S_DRIVE;
          dir_nx = ~at_a;
        end
      end
      S_BOARD: begin
        bp_nx  = here;
        sum    = AW'(revenue) + AW'(here) * fare;
        rev_nx = (sum > AW'(REV_MAX)) ? RW'(REV_MAX) : RW'(sum);
        dir_nx = ~at_a;
        clr_a  = at_a;
        clr_b  = ~at_a;
        st_nx  = S_REFUEL_T;
      end
      S_REFUEL_T, S_REFUEL_G: begin
        if (gas < GW'(GAS_MAX) && AW'(revenue) >= AW'(GAS_COST)) begin
          sum    = AW'(gas) + AW'(GAS_REFILL);
          gas_nx = (sum > AW'(GAS_MAX)) ? GW'(GAS_MAX) : GW'(sum);
          rev_nx = RW'(AW'(revenue) - AW'(GAS_COST));
        end else begin
          st_nx = S_DRIVE;
        end
      end
      S_DRIVE: begin
        pos_nx = dir ? (pos >> 1) : (pos << 1);
        if (pos_nx[0] || pos_nx[NUM_STOPS-1]) begin
          st_nx = (bus_pass != '0) ? S_BURN_T : S_WAIT;
        end else if (pos_nx[GAS_POS] && bus_pass != '0) begin
          st_nx = S_BURN_G;
        end
      end
      S_BURN_T, S_BURN_G: begin
        burn   = AW'(bus_pass) * AW'(GAS_BURN);
        gas_nx = (AW'(gas) > burn) ? GW'(AW'(gas) - burn) : '0;
        st_nx  = (st == S_BURN_T) ? S_ALIGHT : S_REFUEL_G;
      end
      S_ALIGHT: begin
        if (bus_pass <= CW'(1)) begin
          bp_nx = '0;
          st_nx = S_WAIT;
        end else begin
          bp_nx = bus_pass - CW'(1);
        end
      end
      default: st_nx = S_WAIT;
    endcase
  end

  // Queue next values: a boarding clear applies before a same-edge arrival is counted
  always_comb begin
    qa_base = (step && clr_a) ? '0 : wait_a;
    qb_base = (step && clr_b) ? '0 : wait_b;
    qa_nx   = (arrive_a && qa_base != CW'(CAP)) ? qa_base + CW'(1) : qa_base;
    qb_nx   = (arrive_b && qb_base != CW'(CAP)) ? qb_base + CW'(1) : qb_base;
  end

  // Tick divider and passenger queues, updated every clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      wait_a <= '0;
      wait_b <= '0;
    end else begin
      cnt    <= step ? '0 : cnt + TW'(1);
      wait_a <= qa_nx;
      wait_b <= qb_nx;
    end
  end

  // Shuttle registers, advanced once per step tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= S_WAIT;
      bus_pass <= '0;
      pos      <= NUM_STOPS'(1);
      dir      <= 1'b0;
      revenue  <= '0;
      gas      <= '0;
    end else if (step) begin
      st       <= st_nx;
      bus_pass <= bp_nx;
      pos      <= pos_nx;
      dir      <= dir_nx;
      revenue  <= rev_nx;
      gas      <= gas_nx;
    end
  end

endmodule

// File: tb/tb_shuttle_ctrl.sv
// Bench for shuttle_ctrl: directed scenarios plus randomized arrivals checked
// against a step-level reference model of the shuttle rules.
module tb_shuttle_ctrl;

  localparam int TD = 4;
  localparam int NS = 7, GPOS = 3, CAPM = 2, FU = 30, FD = 20, RMAX = 90;
  localparam int GMAX = 20, GREF = 10, GCOST = 10, GBURN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // default-parameter instance
  logic       rst, arrive_a, arrive_b, dir, step;
  logic [1:0] wait_a, wait_b, bus_pass;
  logic [6:0] pos, revenue;
  logic [4:0] gas;
  logic [2:0] state;
  logic [29:0] dut_vec;
  assign dut_vec = {wait_a, wait_b, bus_pass, pos, dir, revenue, gas, state, step};

  shuttle_ctrl #(.TICK_DIV(TD)) u_dut (
    .clk(clk), .rst(rst), .arrive_a(arrive_a), .arrive_b(arrive_b),
    .wait_a(wait_a), .wait_b(wait_b), .bus_pass(bus_pass), .pos(pos), .dir(dir),
    .revenue(revenue), .gas(gas), .state(state), .step(step));

  // larger capacity, shorter route
  logic       rst_p, arrive_a_p, arrive_b_p, dir_p, step_p;
  logic [2:0] wait_a_p, wait_b_p, bus_pass_p, state_p;
  logic [4:0] pos_p, gas_p;
  logic [6:0] revenue_p;

  shuttle_ctrl #(.NUM_STOPS(5), .GAS_POS(2), .CAP(4), .TICK_DIV(TD)) u_par (
    .clk(clk), .rst(rst_p), .arrive_a(arrive_a_p), .arrive_b(arrive_b_p),
    .wait_a(wait_a_p), .wait_b(wait_b_p), .bus_pass(bus_pass_p), .pos(pos_p), .dir(dir_p),
    .revenue(revenue_p), .gas(gas_p), .state(state_p), .step(step_p));

  // expensive, small refuels so revenue runs dry
  logic       rst_l, arrive_a_l, arrive_b_l, dir_l, step_l;
  logic [1:0] wait_a_l, wait_b_l, bus_pass_l;
  logic [6:0] pos_l, revenue_l;
  logic [4:0] gas_l;
  logic [2:0] state_l;

  shuttle_ctrl #(.GAS_REFILL(5), .GAS_COST(60), .TICK_DIV(TD)) u_lim (
    .clk(clk), .rst(rst_l), .arrive_a(arrive_a_l), .arrive_b(arrive_b_l),
    .wait_a(wait_a_l), .wait_b(wait_b_l), .bus_pass(bus_pass_l), .pos(pos_l), .dir(dir_l),
    .revenue(revenue_l), .gas(gas_l), .state(state_l), .step(step_l));

  // reference model: stop index, queue counts, money and fuel as plain integers
  int m_cnt, m_wa, m_wb, m_bp, m_pos, m_dir, m_rev, m_gas, m_st;
  bit m_stepped;

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wa = 0; m_wb = 0; m_bp = 0; m_pos = 0; m_dir = 0;
    m_rev = 0; m_gas = 0; m_st = 0; m_stepped = 0;
  endtask

  function automatic logic [29:0] model_vec();
    logic [6:0] oh;
    oh = '0;
    oh[m_pos] = 1'b1;
    return {2'(m_wa), 2'(m_wb), 2'(m_bp), oh, 1'(m_dir), 7'(m_rev), 5'(m_gas),
            3'(m_st), 1'(m_cnt == TD - 1)};
  endfunction

  task automatic model_edge(input logic a, input logic b);
    int here, other, np;
    bit at_a, clr_a, clr_b, stp;
    stp = (m_cnt == TD - 1);
    clr_a = 0; clr_b = 0;
    if (stp) begin
      at_a  = (m_pos == 0);
      here  = at_a ? m_wa : m_wb;
      other = at_a ? m_wb : m_wa;
      case (m_st)
        0: if (here > 0) m_st = 1;
           else if (other > 0) begin m_st = 3; m_dir = at_a ? 0 : 1; end
        1: begin
          m_bp  = here;
          m_rev = imin(m_rev + here * (at_a ? FU : FD), RMAX);
          m_dir = at_a ? 0 : 1;
          if (at_a) clr_a = 1; else clr_b = 1;
          m_st = 2;
        end
        2, 7: if (m_gas < GMAX && m_rev >= GCOST) begin
                m_gas = imin(m_gas + GREF, GMAX);
                m_rev = m_rev - GCOST;
              end else m_st = 3;
        3: begin
          np = (m_dir != 0) ? m_pos - 1 : m_pos + 1;
          m_pos = np;
          if (np == 0 || np == NS - 1) m_st = (m_bp > 0) ? 4 : 0;
          else if (np == GPOS && m_bp > 0) m_st = 6;
        end
        4, 6: begin
          m_gas = imax(m_gas - m_bp * GBURN, 0);
          m_st  = (m_st == 4) ? 5 : 7;
        end
        5: if (m_bp <= 1) begin m_bp = 0; m_st = 0; end else m_bp = m_bp - 1;
        default: ;
      endcase
    end
    if (clr_a) m_wa = 0;
    if (clr_b) m_wb = 0;
    if (a) m_wa = imin(m_wa + 1, CAPM);
    if (b) m_wb = imin(m_wb + 1, CAPM);
    m_cnt = (m_cnt + 1) % TD;
    m_stepped = stp;
  endtask

  // one clock on the default instance; called and returns at a falling edge
  task automatic tick(input logic a, input logic b);
    arrive_a = a;
    arrive_b = b;
    @(posedge clk);
    model_edge(a, b);
    @(negedge clk);
    arrive_a = 1'b0;
    arrive_b = 1'b0;
  endtask

  task automatic run_steps(input int n);
    int s;
    s = 0;
    while (s < n) begin
      tick(1'b0, 1'b0);
      if (m_stepped) s++;
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (dut_vec !== 30'({2'd0, 2'd0, 2'd0, 7'd1, 1'b0, 7'd0, 5'd0, 3'd0, 1'b0})) begin
      miscompares++; $display("FAIL reset_values: got %h want pos=1 rest 0", dut_vec);
    end
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    vectors++;
    if ({step, state} !== 4'b0_000) begin
      miscompares++; $display("FAIL early_step: got step=%0d state=%0d want 0/0", step, state);
    end
    tick(1'b0, 1'b0);
    vectors++;
    if (step !== 1'b1) begin
      miscompares++; $display("FAIL first_step: got step=%0d want 1", step);
    end
  endtask

  task automatic test_round_trip();
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    vectors++;
    if (wait_a !== 2'd2) begin miscompares++; $display("FAIL rt_queue: got %0d want 2", wait_a); end
    run_steps(1);
    vectors++;
    if (state !== 3'd1) begin miscompares++; $display("FAIL rt_to_board: got %0d want 1", state); end
    run_steps(1);
    vectors++;
    if ({bus_pass, revenue, wait_a, state} !== {2'd2, 7'd60, 2'd0, 3'd2}) begin
      miscompares++; $display("FAIL rt_board: got bp=%0d rev=%0d wa=%0d st=%0d want 2/60/0/2", bus_pass, revenue, wait_a, state);
    end
    run_steps(1);
    vectors++;
    if ({gas, revenue, state} !== {5'd10, 7'd50, 3'd2}) begin
      miscompares++; $display("FAIL rt_refuel1: got gas=%0d rev=%0d st=%0d want 10/50/2", gas, revenue, state);
    end
    run_steps(1);
    vectors++;
    if ({gas, revenue, state} !== {5'd20, 7'd40, 3'd2}) begin
      miscompares++; $display("FAIL rt_refuel2: got gas=%0d rev=%0d st=%0d want 20/40/2", gas, revenue, state);
    end
    run_steps(1);
    vectors++;
    if ({state, pos, dir} !== {3'd3, 7'd1, 1'b0}) begin
      miscompares++; $display("FAIL rt_depart: got st=%0d pos=%b dir=%0d want 3/0000001/0", state, pos, dir);
    end
    run_steps(3);
    vectors++;
    if ({state, pos} !== {3'd6, 7'b0001000}) begin
      miscompares++; $display("FAIL rt_gas_stop: got st=%0d pos=%b want 6/0001000", state, pos);
    end
    run_steps(1);
    vectors++;
    if ({gas, state} !== {5'd10, 3'd7}) begin
      miscompares++; $display("FAIL rt_burn_g: got gas=%0d st=%0d want 10/7", gas, state);
    end
    run_steps(1);
    vectors++;
    if ({gas, revenue, state} !== {5'd20, 7'd30, 3'd7}) begin
      miscompares++; $display("FAIL rt_refuel_g: got gas=%0d rev=%0d st=%0d want 20/30/7", gas, revenue, state);
    end
    run_steps(4);
    vectors++;
    if ({pos, state} !== {7'b1000000, 3'd4}) begin
      miscompares++; $display("FAIL rt_arrive_b: got pos=%b st=%0d want 1000000/4", pos, state);
    end
    run_steps(1);
    vectors++;
    if ({gas, state} !== {5'd10, 3'd5}) begin
      miscompares++; $display("FAIL rt_burn_t: got gas=%0d st=%0d want 10/5", gas, state);
    end
    run_steps(1);
    vectors++;
    if ({bus_pass, state} !== {2'd1, 3'd5}) begin
      miscompares++; $display("FAIL rt_alight1: got bp=%0d st=%0d want 1/5", bus_pass, state);
    end
    run_steps(1);
    vectors++;
    if ({bus_pass, state, pos} !== {2'd0, 3'd0, 7'b1000000}) begin
      miscompares++; $display("FAIL rt_alight0: got bp=%0d st=%0d pos=%b want 0/0/1000000", bus_pass, state, pos);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    vectors++;
    if (wait_b !== 2'd2) begin miscompares++; $display("FAIL sat_queue: got %0d want 2", wait_b); end
    run_steps(1);
    vectors++;
    if ({state, dir} !== {3'd3, 1'b0}) begin
      miscompares++; $display("FAIL sat_depart: got st=%0d dir=%0d want 3/0", state, dir);
    end
    run_steps(3);
    vectors++;
    if ({state, pos, gas} !== {3'd3, 7'b0001000, 5'd0}) begin
      miscompares++; $display("FAIL sat_pass_gas: got st=%0d pos=%b gas=%0d want 3/0001000/0", state, pos, gas);
    end
    run_steps(3);
    vectors++;
    if ({state, pos, bus_pass} !== {3'd0, 7'b1000000, 2'd0}) begin
      miscompares++; $display("FAIL sat_at_b: got st=%0d pos=%b bp=%0d want 0/1000000/0", state, pos, bus_pass);
    end
    run_steps(2);
    vectors++;
    if ({revenue, bus_pass, wait_b, state} !== {7'd40, 2'd2, 2'd0, 3'd2}) begin
      miscompares++; $display("FAIL sat_board_b: got rev=%0d bp=%0d wb=%0d st=%0d want 40/2/0/2", revenue, bus_pass, wait_b, state);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    run_steps(1);
    while (m_cnt != TD - 1) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    vectors++;
    if ({bus_pass, wait_a, state} !== {2'd2, 2'd1, 3'd2}) begin
      miscompares++; $display("FAIL simul_board: got bp=%0d wa=%0d st=%0d want 2/1/2", bus_pass, wait_a, state);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    guard = 0;
    while (!(m_st == 3 && m_pos == 4) && guard < 400) begin
      tick(1'b0, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 400 || pos !== 7'b0010000 || state !== 3'd3) begin
      miscompares++; $display("FAIL midrst_reach: got pos=%b st=%0d want 0010000/3", pos, state);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++; $display("FAIL midrst_async: got %h want %h", dut_vec, model_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++; $display("FAIL midrst_resume cyc %0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_param();
    @(negedge clk);
    rst_p = 1'b1;
    arrive_a_p = 1'b1;
    clocks(4);
    arrive_a_p = 1'b0;
    vectors++;
    if ({wait_a_p, state_p} !== {3'd4, 3'd1}) begin
      miscompares++; $display("FAIL par_queue: got wa=%0d st=%0d want 4/1", wait_a_p, state_p);
    end
    clocks(4);
    vectors++;
    if ({bus_pass_p, revenue_p, state_p} !== {3'd4, 7'd90, 3'd2}) begin
      miscompares++; $display("FAIL par_board_sat: got bp=%0d rev=%0d st=%0d want 4/90/2", bus_pass_p, revenue_p, state_p);
    end
    clocks(8);
    vectors++;
    if ({gas_p, revenue_p} !== {5'd20, 7'd70}) begin
      miscompares++; $display("FAIL par_refuel: got gas=%0d rev=%0d want 20/70", gas_p, revenue_p);
    end
    clocks(4);
    vectors++;
    if ({state_p, pos_p} !== {3'd3, 5'b00001}) begin
      miscompares++; $display("FAIL par_depart: got st=%0d pos=%b want 3/00001", state_p, pos_p);
    end
    clocks(8);
    vectors++;
    if ({state_p, pos_p} !== {3'd6, 5'b00100}) begin
      miscompares++; $display("FAIL par_gas_stop: got st=%0d pos=%b want 6/00100", state_p, pos_p);
    end
    clocks(4);
    vectors++;
    if ({gas_p, state_p} !== {5'd0, 3'd7}) begin
      miscompares++; $display("FAIL par_burn: got gas=%0d st=%0d want 0/7", gas_p, state_p);
    end
  endtask

  task automatic test_refuel_limit();
    @(negedge clk);
    rst_l = 1'b1;
    arrive_a_l = 1'b1;
    clocks(2);
    arrive_a_l = 1'b0;
    clocks(2);
    vectors++;
    if ({wait_a_l, state_l} !== {2'd2, 3'd1}) begin
      miscompares++; $display("FAIL lim_to_board: got wa=%0d st=%0d want 2/1", wait_a_l, state_l);
    end
    clocks(4);
    vectors++;
    if ({bus_pass_l, revenue_l, state_l} !== {2'd2, 7'd60, 3'd2}) begin
      miscompares++; $display("FAIL lim_board: got bp=%0d rev=%0d st=%0d want 2/60/2", bus_pass_l, revenue_l, state_l);
    end
    clocks(4);
    vectors++;
    if ({gas_l, revenue_l, state_l} !== {5'd5, 7'd0, 3'd2}) begin
      miscompares++; $display("FAIL lim_refuel: got gas=%0d rev=%0d st=%0d want 5/0/2", gas_l, revenue_l, state_l);
    end
    clocks(4);
    vectors++;
    if (state_l !== 3'd3) begin miscompares++; $display("FAIL lim_exit_t: got st=%0d want 3", state_l); end
    clocks(12);
    vectors++;
    if ({state_l, pos_l, gas_l} !== {3'd6, 7'b0001000, 5'd5}) begin
      miscompares++; $display("FAIL lim_gas_stop: got st=%0d pos=%b gas=%0d want 6/0001000/5", state_l, pos_l, gas_l);
    end
    clocks(4);
    vectors++;
    if ({gas_l, state_l} !== {5'd0, 3'd7}) begin
      miscompares++; $display("FAIL lim_burn_clamp: got gas=%0d st=%0d want 0/7", gas_l, state_l);
    end
    clocks(4);
    vectors++;
    if ({gas_l, revenue_l, state_l} !== {5'd0, 7'd0, 3'd3}) begin
      miscompares++; $display("FAIL lim_exit_g: got gas=%0d rev=%0d st=%0d want 0/0/3", gas_l, revenue_l, state_l);
    end
  endtask

  initial begin
    rst = 1'b0; arrive_a = 1'b0; arrive_b = 1'b0;
    rst_p = 1'b0; arrive_a_p = 1'b0; arrive_b_p = 1'b0;
    rst_l = 1'b0; arrive_a_l = 1'b0; arrive_b_l = 1'b0;
    test_reset();
    test_round_trip();
    test_saturation();
    test_simultaneous();
    test_random();
    test_mid_reset();
    test_param();
    test_refuel_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shuttle_ctrl.md
# shuttle_ctrl

Parametrised two-terminal shuttle controller: passengers queue at terminal A (stop 0) and terminal B (stop NUM_STOPS-1), the shuttle boards them, drives one stop per step tick, burns fuel per passenger, refuels at terminals and at a mid-route gas stop, and collects fares.

The block runs from one clock domain and derives its step rate from an internal tick counter, so it uses no gated or muxed clocks. It feeds the board's LED/7-segment display logic and takes passenger-arrival pulses from the keyboard decode logic.

## Interface
- NUM_STOPS, 7, route length in stops (≥3); stop 0 = A, NUM_STOPS-1 = B
- GAS_POS, 3, gas-stop index (0 < GAS_POS < NUM_STOPS-1)
- CAP, 2, per-terminal queue limit and shuttle capacity
- FARE_UP, 30, fare per passenger boarding at A
- FARE_DOWN, 20, fare per passenger boarding at B
- REV_MAX, 90, revenue saturation value
- GAS_MAX, 20, tank size
- GAS_REFILL, 10, gas added per refuel step
- GAS_COST, 10, revenue spent per refuel step
- GAS_BURN, 5, gas burned per passenger on each fuel-burn event
- TICK_DIV, 2**26, clk cycles per FSM step (≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- arrive_a  in  1  one-cycle pulse: one passenger arrives at A
- arrive_b  in  1  one-cycle pulse: one passenger arrives at B
- wait_a  out  clog2(CAP+1)  passengers queued at A
- wait_b  out  clog2(CAP+1)  passengers queued at B
- bus_pass  out  clog2(CAP+1)  passengers on board
- pos  out  NUM_STOPS  one-hot shuttle position
- dir  out  1  0 = toward B (increasing pos), 1 = toward A
- revenue  out  clog2(REV_MAX+1)  accumulated revenue
- gas  out  clog2(GAS_MAX+1)  fuel level
- state  out  3  FSM state code
- step  out  1  one-cycle tick strobe

## Operation
- Tick counter: counts 0..TICK_DIV-1 on every clk cycle. `step`=1 in the cycle where the count equals TICK_DIV-1. The FSM and all shuttle registers update only on clk edges where `step`=1.
- Queues: update on any clk edge. An arrive pulse increments the matching queue, saturating at CAP; extra pulses are dropped.
- State codes: WAIT=0, BOARD=1, REFUEL_T=2, DRIVE=3, BURN_T=4, ALIGHT=5, BURN_G=6, REFUEL_G=7.
- "here" is the queue at the current terminal; "other" is the opposite queue.
- WAIT: if here>0 → BOARD. Else if other>0 → DRIVE, with dir set to 0 at A and 1 at B. Else stay in WAIT.
- BOARD:
  - bus_pass ← here; here ← 0.
  - revenue ← min(revenue + here×fare, REV_MAX). The fare is FARE_UP at A and FARE_DOWN at B.
  - dir is set as in WAIT; next state → REFUEL_T.
  - If an arrive pulse for this terminal lands in the same cycle, the queue becomes 1 (the boarded passengers are cleared first, then the new arrival is counted).
- REFUEL_T / REFUEL_G: if gas<GAS_MAX and revenue≥GAS_COST, then gas ← min(gas+GAS_REFILL, GAS_MAX), revenue −= GAS_COST, and stay. Otherwise → DRIVE.
- DRIVE: pos moves one stop per step in direction dir. Next state is chosen from the new position:
  - New position is a terminal: → BURN_T if bus_pass>0, else → WAIT.
  - New position is GAS_POS: → BURN_G if bus_pass>0, else stay in DRIVE. An empty shuttle does not stop for gas.
- BURN_T / BURN_G: gas ← max(gas − bus_pass×GAS_BURN, 0). Then BURN_T → ALIGHT and BURN_G → REFUEL_G.
- ALIGHT: bus_pass −= 1 per step. On the step where bus_pass is 1, it becomes 0 and the state → WAIT.
- Zero gas does not stall the shuttle.
- All arithmetic is done at a width of at least clog2(REV_MAX+CAP×max(FARE)+1) before saturating, so no intermediate sum wraps.

## Timing
- Reset (rst=0): asynchronous. All outputs and the tick count clear immediately: pos=1 (stop A), state=WAIT, dir=0, and every counter is 0. This applies mid-trip as well. The first step after reset release occurs TICK_DIV cycles later.
- Queue latency: 1 clk.
- FSM latency: one step per state. The boarding-to-departure sequence is BOARD, then k REFUEL_T steps, then 1 REFUEL_T exit step, then DRIVE.
- Outputs are registered. There are no combinational paths from inputs to outputs except through the queue registers.

## Test plan
- Round trip, defaults, TICK_DIV=4:
  - Stimulus: 2× arrive_a.
  - BOARD: bus_pass=2, revenue=60.
  - REFUEL_T: gas/revenue go 10/50, then 20/40.
  - DRIVE pos 1→3, then BURN_G gives gas=10; REFUEL_G gives 20/30.
  - DRIVE to pos 6, then BURN_T gives gas=10; ALIGHT gives 2→1→0; state ends in WAIT at B.
- Saturation: 3× arrive_b while the shuttle is at A → wait_b=2. The shuttle then drives empty past stop 3 with gas unchanged and reaches WAIT at B. The next step goes to BOARD, giving revenue=40.
- Simultaneous event: arrive_a on the same edge as BOARD at A → bus_pass=2, wait_a=1.
- Parametrised run with CAP=4, NUM_STOPS=5, GAS_POS=2: 4× arrive_a → revenue saturates at 90. Refuel to gas=20 leaves revenue=70. pos is 5 bits wide.
- Refuel limit: revenue=0 at REFUEL_G → exits to DRIVE after 1 step with gas unchanged. Burning with gas=5 and bus_pass=2 → gas=0.
- Reset mid-DRIVE at pos 4 → all outputs return to their reset values within the same cycle. Normal operation resumes after rst is released.
